wb_apb_bridge: RTL
==================

# wb_apb_bridge

Wishbone-classic responder that accepts single read/write cycles from the Wishbone interconnect's APB-region slave port (0x1000_0000 region) and reissues each as one APB transfer (SETUP then ACCESS) to the peripheral bus. It returns read data and a one-cycle acknowledge to the interconnect. An ACCESS-phase timeout prevents a dead peripheral from hanging the CPU, and a sticky error flag records slave errors and timeouts.

## Interface
- AW, 32, Wishbone address width
- DW, 32, data width (Wishbone and APB)
- PAW, 16, APB address width; paddr = wb_adr[PAW-1:0]
- TIMEOUT, 255, maximum ACCESS cycles without pready before forced completion (1..65535)

Clock and reset: one clock; reset is asynchronous and active-low.

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wb_cyc  in  1  Wishbone cycle valid
- wb_stb  in  1  Wishbone strobe
- wb_we  in  1  1 = write
- wb_adr  in  AW  byte address
- wb_wdata  in  DW  write data
- wb_rdata  out  DW  read data, valid while wb_ack=1
- wb_ack  out  1  single-cycle acknowledge
- paddr  out  PAW  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DW  APB write data
- prdata  in  DW  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error
- err_clr  in  1  clears err_flag and err_code
- err_flag  out  1  sticky: an error occurred
- err_code  out  2  01 = pslverr, 10 = timeout (last error wins)

## Operation
- FSM states: IDLE, SETUP, ACCESS, ACK. All outputs are registered.
- IDLE:
  - On wb_cyc&wb_stb: latch adr[PAW-1:0], we, wdata into paddr/pwrite/pwdata; go to SETUP.
  - The IDLE->SETUP edge sets psel=1, penable=0.
- SETUP: one cycle, then ACCESS with penable=1. paddr, pwrite and pwdata stay stable.
- ACCESS: the timeout counter increments every cycle.
  - pready=1: capture prdata (reads only; writes return 0) into wb_rdata. If pslverr, set err_flag and err_code=01. Go to ACK.
  - Counter reaches TIMEOUT-1 without pready: wb_rdata=0, err_flag=1, err_code=10, go to ACK.
  - Leaving ACCESS clears psel, penable and the counter.
- ACK: wb_ack=1 for exactly one cycle, then IDLE. wb_rdata returns to 0 when wb_ack falls.
- Abort: wb_cyc low at any point after SETUP is entered.
  - The APB transfer still completes; the protocol forbids abort.
  - ACK is replaced by a silent return to IDLE, so wb_ack stays 0.
  - Captured data is discarded.
- Back-to-back: wb_stb high in the cycle after ACK starts a new transfer. No stb edge is required.
- err_clr:
  - Clears err_flag and err_code on the next edge.
  - If err_clr coincides with a new error, the new error wins.
- wb_adr bits above PAW are ignored. Region decode belongs to the interconnect.

## Timing
- Reset values: wb_ack=0, wb_rdata=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, err_flag=0, err_code=00, state=IDLE, counter=0.
- Reset asserted mid-transfer forces all of the above immediately (asynchronous). No ACK is issued after reset release.
- Cycle numbering: edge 0 samples wb_stb.
  - psel=1 in cycle 1.
  - psel=penable=1 from cycle 2.
  - With pready=1 in cycle 2, wb_ack=1 in cycle 3. Minimum latency is 3 cycles.
- Each APB wait state adds one cycle.
- Timeout: ACCESS lasts exactly TIMEOUT cycles, and ack follows TIMEOUT+2 cycles after edge 0.
- Throughput: at most one transfer per 4 cycles. psel is low for at least the ACK and IDLE cycles between transfers.
- pready and pslverr are sampled only when psel&penable. Values at other times are ignored.

## Test plan
- Zero-wait write: wb write adr=0x1000_0010, wdata=0xA5A5_5A5A.
  - Expect paddr=0x0010, pwrite=1 and pwdata stable through SETUP and ACCESS.
  - Expect wb_ack one cycle, 3 cycles after stb; err_flag=0.
- Read with 2 wait states: prdata=0x1234_5678 with pready at the 3rd ACCESS cycle.
  - Expect wb_ack at cycle 5 with wb_rdata=0x1234_5678, then wb_rdata=0 afterwards.
- Slave error: read with pslverr=1 and pready=1.
  - Expect wb_ack, err_flag=1 and err_code=01.
  - Pulse err_clr: flag and code return to 0 next cycle.
- Timeout with TIMEOUT=8 and pready stuck low.
  - Expect penable high for exactly 8 cycles, then wb_ack with wb_rdata=0 and err_code=10.
- Abort and reset:
  - Drop wb_cyc during ACCESS: APB completes on pready and wb_ack never asserts.
  - Assert rst_n=0 mid-ACCESS: psel, penable and wb_ack drop immediately.
- Back-to-back: hold stb across two transfers (write then read).
  - Expect two acks 4 cycles apart with no overlapping psel.

Source files
------------

// File: rtl/wb_apb_bridge.sv
// Wishbone-classic responder that reissues each single read/write cycle as
// one APB transfer (SETUP then ACCESS), with an ACCESS timeout and sticky error.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   wb_cyc, wb_stb       Wishbone cycle / strobe
//   wb_we, wb_adr        direction (1 = write), byte address
//   wb_wdata, wb_rdata   write data in, read data out (valid while wb_ack)
//   wb_ack               single-cycle acknowledge
//   paddr, psel          APB address (wb_adr[PAW-1:0]), select
//   penable, pwrite      APB enable, direction
//   pwdata, prdata       APB write data out, read data in
//   pready, pslverr      APB ready, slave error
//   err_clr              clears the sticky error flag and code
//   err_flag, err_code   sticky error; code 01 = pslverr, 10 = timeout
module wb_apb_bridge #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int PAW     = 16,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wb_cyc,
    input  logic           wb_stb,
    input  logic           wb_we,
    input  logic [AW-1:0]  wb_adr,
    input  logic [DW-1:0]  wb_wdata,
    output logic [DW-1:0]  wb_rdata,
    output logic           wb_ack,
    output logic [PAW-1:0] paddr,
    output logic           psel,
    output logic           penable,
    output logic           pwrite,
    output logic [DW-1:0]  pwdata,
    input  logic [DW-1:0]  prdata,
    input  logic           pready,
    input  logic           pslverr,
    input  logic           err_clr,
    output logic           err_flag,
    output logic [1:0]     err_code
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_ACK    = 2'd3;

    localparam int CW = 16;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] E_SLVERR  = 2'b01;
    localparam logic [1:0] E_TIMEOUT = 2'b10;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           abort_q, abort_d;
    logic [PAW-1:0] paddr_q, paddr_d;
    logic           psel_q, psel_d;
    logic           penable_q, penable_d;
    logic           pwrite_q, pwrite_d;
    logic [DW-1:0]  pwdata_q, pwdata_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic           ack_q, ack_d;
    logic           err_flag_q, err_flag_d;
    logic [1:0]     err_code_q, err_code_d;

    logic acc_hit;
    logic acc_tmo;

    // Region decode is done by the interconnect; upper address bits are dropped.
    logic unused_adr;
    assign unused_adr = ^wb_adr[AW-1:PAW];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        abort_d    = abort_q;
        paddr_d    = paddr_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        rdata_d    = rdata_q;
        ack_d      = 1'b0;
        err_flag_d = err_flag_q;
        err_code_d = err_code_q;
        acc_hit    = 1'b0;
        acc_tmo    = 1'b0;

        case (state_q)
            S_IDLE: begin
                rdata_d = '0;
                abort_d = 1'b0;
                if (wb_cyc && wb_stb) begin
                    paddr_d   = wb_adr[PAW-1:0];
                    pwrite_d  = wb_we;
                    pwdata_d  = wb_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                abort_d   = abort_q | ~wb_cyc;
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                // A dropped cycle is remembered but the APB transfer runs on:
                // APB has no way to abort an ACCESS phase.
                abort_d = abort_q | ~wb_cyc;
                cnt_d   = cnt_q + 1'b1;
                acc_hit = pready;
                acc_tmo = !pready && (cnt_q == CNT_LAST);
                if (acc_hit || acc_tmo) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                    if (abort_d) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                        rdata_d = (acc_hit && !pwrite_q) ? prdata : '0;
                    end
                end
            end
            S_ACK: begin
                rdata_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new error in the same cycle as err_clr takes precedence.
        if (err_clr) begin
            err_flag_d = 1'b0;
            err_code_d = 2'b00;
        end
        if (acc_hit && pslverr) begin
            err_flag_d = 1'b1;
            err_code_d = E_SLVERR;
        end else if (acc_tmo) begin
            err_flag_d = 1'b1;
            err_code_d = E_TIMEOUT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            abort_q    <= 1'b0;
            paddr_q    <= '0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            err_flag_q <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            abort_q    <= abort_d;
            paddr_q    <= paddr_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            err_flag_q <= err_flag_d;
            err_code_q <= err_code_d;
        end
    end

    assign wb_rdata = rdata_q;
    assign wb_ack   = ack_q;
    assign paddr    = paddr_q;
    assign psel     = psel_q;
    assign penable  = penable_q;
    assign pwrite   = pwrite_q;
    assign pwdata   = pwdata_q;
    assign err_flag = err_flag_q;
    assign err_code = err_code_q;

endmodule
